bht_ram_predictor: RTL and testbench



---
 rtl/bht_ram_predictor.sv | 198 +++++++++++++++++++
 tb/tb_bht_ram_predictor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bht_ram_predictor.sv
// Banked branch history table: one {valid, 2-bit counter} RAM per fetch slot, 1-cycle lookup, pipelined forwarded updates.
// Optional macro BHT_WR_BYPASS_EN forwards a write landing on the row being looked up into the next prediction.
module bht_ram_bank #(
    parameter int unsigned ROWS = 512,
    parameter int unsigned RW   = 9
) (
    input  logic          clk_i,
    input  logic [RW-1:0] ra_addr_i,
    output logic [1:0]    ra_data_o,
    input  logic [RW-1:0] rb_addr_i,
    output logic [1:0]    rb_data_o,
    input  logic          we_i,
    input  logic [RW-1:0] waddr_i,
    input  logic [2:0]    wdata_i
);
    logic [2:0] mem [ROWS];
    logic [1:0] ra_q;
    logic [1:0] rb_q;

    // Port A feeds prediction {valid, taken}; port B feeds the update counter.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        ra_q <= mem[ra_addr_i][2:1];
        rb_q <= mem[rb_addr_i][1:0];
    end

    assign ra_data_o = ra_q;
    assign rb_data_o = rb_q;
endmodule

module bht_ram_predictor #(
    parameter int unsigned VLEN            = 64,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned NR_ENTRIES      = 1024,
    parameter int unsigned INDEX_BITS      = $clog2(NR_ENTRIES)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      flush_bp_i,
    input  logic                                      debug_mode_i,
    input  logic [VLEN-1:0]                           vpc_i,
    input  logic [1+VLEN+1+INDEX_BITS-1:0]            bht_update_i,
    output logic [INSTR_PER_FETCH*(2+INDEX_BITS)-1:0] bht_prediction_o
);
    localparam int unsigned NR_ROWS   = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned BANK_BITS = $clog2(INSTR_PER_FETCH);
    localparam int unsigned ROW_BITS  = $clog2(NR_ROWS);
    localparam int unsigned OFF       = BANK_BITS + 1;
    localparam int unsigned UPD_W     = 2 + VLEN + INDEX_BITS;
    localparam int unsigned SLOT_W    = 2 + INDEX_BITS;

    typedef enum logic {IDLE, SWEEP} state_e;

    state_e                state_q;
    logic [ROW_BITS-1:0]   sweep_row_q;
    logic                  sweep_act;

    logic                  upd_vld;
    logic                  upd_taken;
    logic [INDEX_BITS-1:0] upd_idx;
    logic                  upd_acc;

    logic                  upd_vld_q;
    logic                  upd_taken_q;
    logic [INDEX_BITS-1:0] upd_idx_q;
    logic                  upd_we;

    logic                  fwd_vld_q;
    logic [INDEX_BITS-1:0] fwd_idx_q;
    logic [1:0]            fwd_ctr_q;

    logic [1:0]            old_ctr;
    logic [1:0]            ctr_new;

    logic [ROW_BITS-1:0]   vpc_row;
    logic [ROW_BITS-1:0]   pred_row_q;
    logic                  pred_en_q;
    logic                  pred_en_d;

    logic [ROW_BITS-1:0]   waddr;
    logic [2:0]            wdata;

    logic [1:0]            ra_dat [INSTR_PER_FETCH];
    logic [1:0]            rb_dat [INSTR_PER_FETCH];

    logic                  unused_bits;

    assign upd_vld   = bht_update_i[UPD_W-1];
    assign upd_taken = bht_update_i[INDEX_BITS];
    assign upd_idx   = bht_update_i[INDEX_BITS-1:0];
    assign vpc_row   = vpc_i[OFF +: ROW_BITS];
    // The update pc and the vpc bits outside the row field do not take part in addressing.
    assign unused_bits = ^{bht_update_i[UPD_W-2:INDEX_BITS+1], vpc_i[VLEN-1:OFF+ROW_BITS], vpc_i[OFF-1:0]};

    assign sweep_act = (state_q == SWEEP);
    assign upd_acc   = upd_vld && !debug_mode_i && !sweep_act && !flush_bp_i;
    assign upd_we    = upd_vld_q && !sweep_act;
    assign pred_en_d = !(flush_bp_i || sweep_act);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            sweep_row_q <= '0;
        end else if (flush_bp_i) begin
            state_q     <= SWEEP;
            sweep_row_q <= '0;
        end else if (state_q == SWEEP) begin
            sweep_row_q <= sweep_row_q + 1'b1;
            if (sweep_row_q == ROW_BITS'(NR_ROWS - 1)) begin
                state_q <= IDLE;
            end
        end
    end

    // The RAM read in cycle U misses the write landing at the same edge; take it from the forward register.
    always_comb begin
        old_ctr = rb_dat[upd_idx_q[BANK_BITS-1:0]];
        if (fwd_vld_q && (fwd_idx_q == upd_idx_q)) begin
            old_ctr = fwd_ctr_q;
        end
        ctr_new = old_ctr;
        if (upd_taken_q) begin
            if (old_ctr != 2'b11) ctr_new = old_ctr + 2'd1;
        end else begin
            if (old_ctr != 2'b00) ctr_new = old_ctr - 2'd1;
        end
    end

    assign waddr = sweep_act ? sweep_row_q : upd_idx_q[INDEX_BITS-1:BANK_BITS];
    assign wdata = sweep_act ? 3'b000 : {1'b1, ctr_new};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            upd_vld_q   <= 1'b0;
            upd_taken_q <= 1'b0;
            upd_idx_q   <= '0;
            fwd_vld_q   <= 1'b0;
            fwd_idx_q   <= '0;
            fwd_ctr_q   <= 2'b00;
            pred_en_q   <= 1'b0;
            pred_row_q  <= '0;
        end else begin
            upd_vld_q   <= upd_acc;
            upd_taken_q <= upd_taken;
            upd_idx_q   <= upd_idx;
            fwd_vld_q   <= upd_we;
            fwd_idx_q   <= upd_idx_q;
            fwd_ctr_q   <= ctr_new;
            pred_en_q   <= pred_en_d;
            pred_row_q  <= vpc_row;
        end
    end

    for (genvar b = 0; b < INSTR_PER_FETCH; b++) begin : gen_bht_ram
        logic       we;
        logic [1:0] ent;

        assign we = sweep_act || (upd_we && (upd_idx_q[BANK_BITS-1:0] == BANK_BITS'(b)));

        bht_ram_bank #(
            .ROWS (NR_ROWS),
            .RW   (ROW_BITS)
        ) i_bht_ram (
            .clk_i     (clk_i),
            .ra_addr_i (vpc_row),
            .ra_data_o (ra_dat[b]),
            .rb_addr_i (upd_idx[INDEX_BITS-1:BANK_BITS]),
            .rb_data_o (rb_dat[b]),
            .we_i      (we),
            .waddr_i   (waddr),
            .wdata_i   (wdata)
        );

`ifdef BHT_WR_BYPASS_EN
        logic       byp_q;
        logic [1:0] byp_dat_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                byp_q     <= 1'b0;
                byp_dat_q <= 2'b00;
            end else begin
                byp_q     <= we && (waddr == vpc_row);
                byp_dat_q <= wdata[2:1];
            end
        end

        assign ent = byp_q ? byp_dat_q : ra_dat[b];
`else
        assign ent = ra_dat[b];
`endif

        assign bht_prediction_o[b*SLOT_W +: SLOT_W] =
            pred_en_q ? {ent[1], ent[0], pred_row_q, BANK_BITS'(b)} : '0;
    end
endmodule

// File: tb/tb_bht_ram_predictor.sv
// Directed and random checks of bht_ram_predictor against a serialized-counter shadow model.
module tb_bht_ram_predictor;
    localparam int NR_ROWS = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        debug = 1'b0;
    logic [63:0] vpc = '0;
    logic [75:0] upd = '0;
    logic [23:0] pred;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model state: visible RAM image, one in-flight write, remaining flush window.
    logic [2:0]  mem_m [2][NR_ROWS];
    bit          pend_vld = 1'b0;
    int          pend_b, pend_r;
    logic [2:0]  pend_val;
    int          sweep_left = 0;
    logic [23:0] exp_pred = '0;

    bht_ram_predictor dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flush_bp_i       (flush),
        .debug_mode_i     (debug),
        .vpc_i            (vpc),
        .bht_update_i     (upd),
        .bht_prediction_o (pred)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] lookup(input int r, input bit act);
        logic [8:0] rr;
        rr = 9'(r);
        if (!act) return '0;
        return {mem_m[1][r][2], mem_m[1][r][1], rr, 1'b1,
                mem_m[0][r][2], mem_m[0][r][1], rr, 1'b0};
    endfunction

    function automatic logic [63:0] row_addr(input int r);
        logic [63:0] a;
        a = {$urandom, $urandom};
        a[10:2] = 9'(r);
        return a;
    endfunction

    task automatic land();
        if (pend_vld) mem_m[pend_b][pend_r] = pend_val;
        pend_vld = 1'b0;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_pred   = '0;
            pend_vld   = 1'b0;
            sweep_left = 0;
        end else begin
            bit active;
            int c;
            active = (sweep_left == 0) && !flush;
`ifdef BHT_WR_BYPASS_EN
            land();
            exp_pred = lookup(int'(vpc[10:2]), active);
`else
            exp_pred = lookup(int'(vpc[10:2]), active);
            land();
`endif
            if (upd[75] && !debug && !flush && sweep_left == 0) begin
                pend_b = int'(upd[0]);
                pend_r = int'(upd[9:1]);
                c = int'(mem_m[pend_b][pend_r][1:0]);
                c = upd[10] ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
                pend_val = {1'b1, 2'(c)};
                pend_vld = 1'b1;
            end
            if (flush) begin
                for (int b = 0; b < 2; b++)
                    for (int r = 0; r < NR_ROWS; r++) mem_m[b][r] = 3'b000;
                sweep_left = NR_ROWS;
            end else if (sweep_left > 0) begin
                sweep_left--;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) check("pred_vs_model", pred, exp_pred);
    end

    task automatic send(input bit taken, input int idx, input logic [63:0] pc);
        @(negedge clk);
        upd = {1'b1, pc, taken, 10'(idx)};
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        upd   = '0;
        debug = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] v;
        int          bad;
        for (int r = 0; r < NR_ROWS; r++) begin
            v = $urandom;
            dut.gen_bht_ram[0].i_bht_ram.mem[r] = v[2:0];
            dut.gen_bht_ram[1].i_bht_ram.mem[r] = v[5:3];
            mem_m[0][r] = v[2:0];
            mem_m[1][r] = v[5:3];
        end
        dut.gen_bht_ram[0].i_bht_ram.mem[5]  = 3'b111; mem_m[0][5]  = 3'b111;
        dut.gen_bht_ram[1].i_bht_ram.mem[5]  = 3'b100; mem_m[1][5]  = 3'b100;
        dut.gen_bht_ram[0].i_bht_ram.mem[7]  = 3'b001; mem_m[0][7]  = 3'b001;
        dut.gen_bht_ram[0].i_bht_ram.mem[12] = 3'b010; mem_m[0][12] = 3'b010;
        dut.gen_bht_ram[0].i_bht_ram.mem[9]  = 3'b001; mem_m[0][9]  = 3'b001;

        repeat (3) @(negedge clk);
        check("reset_pred", pred, 24'h0);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // Preloaded row 5 lookup
        @(negedge clk);
        vpc = row_addr(5);
        @(negedge clk);
        check("row5_pred", pred, {1'b1, 1'b0, 9'd5, 1'b1, 1'b1, 1'b1, 9'd5, 1'b0});
        check("row5_model", exp_pred, {1'b1, 1'b0, 9'd5, 1'b1, 1'b1, 1'b1, 9'd5, 1'b0});

        // Saturate low then high on {5,1}
        repeat (3) send(1'b0, 11, row_addr(5));
        idle(2);
        check("sat_low_mem", dut.gen_bht_ram[1].i_bht_ram.mem[5], 3'b100);
        repeat (4) send(1'b1, 11, row_addr(5));
        idle(2);
        check("sat_high_mem", dut.gen_bht_ram[1].i_bht_ram.mem[5], 3'b111);
        check("sat_high_model", mem_m[1][5], 3'b111);
        check("row5_taken1", pred[23:22], 2'b11);

        // Back-to-back taken updates on {7,0} from counter 01
        send(1'b1, 14, row_addr(7));
        send(1'b1, 14, row_addr(7));
        idle(2);
        check("fwd_mem", dut.gen_bht_ram[0].i_bht_ram.mem[7], 3'b111);

        // Update in debug mode is ignored
        @(negedge clk);
        debug = 1'b1;
        upd   = {1'b1, row_addr(12), 1'b1, 10'd24};
        idle(2);
        check("debug_mem", dut.gen_bht_ram[0].i_bht_ram.mem[12], 3'b010);

        // pc pointing at row 9, index naming {12,0}
        send(1'b1, 24, row_addr(9));
        idle(2);
        check("pc_idx_mem12", dut.gen_bht_ram[0].i_bht_ram.mem[12], 3'b111);
        check("pc_idx_mem9", dut.gen_bht_ram[0].i_bht_ram.mem[9], 3'b001);
        check("pc_idx_model12", mem_m[0][12], 3'b111);

        // Flush sweep
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bad = 0;
        repeat (NR_ROWS) begin
            @(negedge clk);
            vpc = row_addr($urandom_range(0, NR_ROWS - 1));
            upd = {1'b1, row_addr(5), 1'b1, 10'd11};
            if (pred[23] || pred[11]) bad++;
        end
        upd = '0;
        check("flush_window_valids", bad, 0);
        bad = 0;
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            vpc = row_addr(r);
            if (pred[23] || pred[11]) bad++;
        end
        @(negedge clk);
        check("after_flush_valids", bad, 0);
        check("after_flush_mem5", dut.gen_bht_ram[1].i_bht_ram.mem[5], 3'b000);

        // Random stream on a small index set so forwarding paths are exercised
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            vpc   = row_addr($urandom_range(0, 15));
            upd   = {($urandom_range(0, 1) == 1), {$urandom, $urandom},
                     ($urandom_range(0, 1) == 1), 10'($urandom_range(0, 31))};
            debug = ($urandom_range(0, 15) == 0);
            flush = ($urandom_range(0, 3999) == 0);
        end
        @(negedge clk);
        flush = 1'b0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
